// File: rtl/register_write_pkg.sv
// Shared types and constants for the writeback selector and its receive buffer.
package register_write_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    // Writeback data source selected by MemtoReg
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_ALU  = 2'b10,
        SRC_PC   = 2'b11
    } wb_src_e;

    // UART read sequencing
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT_IN = 2'b01,
        HOLD    = 2'b10
    } wb_state_e;

endpackage

// File: rtl/rx_byte_fifo.sv
// UART receive byte buffer.
// RW_RX_FIFO_EN defined: DEPTH-entry circular FIFO (DEPTH a power of two, >= 2).
// Undefined: single-entry holding register, DEPTH only sizes the count port.
module rx_byte_fifo
    import register_write_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [UART_BYTE_W-1:0]     wr_data,
    output logic [UART_BYTE_W-1:0]     rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

`ifdef RW_RX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [UART_BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;
    logic                   do_push;
    logic                   do_pop;

    // A push into a full buffer is allowed only when a pop frees a slot the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Storage array, no reset needed since reads are gated by count
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
`else
    logic [UART_BYTE_W-1:0] data_q;
    logic                   valid_q;
    logic                   do_push;
    logic                   do_pop;

    assign do_pop  = pop && valid_q;
    assign do_push = push && (!valid_q || do_pop);

    assign full    = valid_q;
    assign empty   = !valid_q;
    assign count   = CNT_W'(valid_q);
    assign rd_data = data_q;

    // Single holding register with its occupancy flag
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (do_push) begin
                data_q <= wr_data;
            end
            if (do_push) begin
                valid_q <= 1'b1;
            end else if (do_pop) begin
                valid_q <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/register_write_buffered.sv
// Writeback-stage data selector and register-file write strobe with a buffered
// UART receive path. Receive buffer depth is selected by RW_RX_FIFO_EN.
module register_write_buffered
    import register_write_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INST_MEM_WIDTH = 2,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      distinct,
    input  logic [1:0]                MemtoReg,
    input  logic                      UARTtoReg,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [INST_MEM_WIDTH-1:0] pc,
    input  logic [UART_BYTE_W-1:0]    rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready,
    output logic                      reg_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] reg_write_addr,
    output logic [DATA_WIDTH-1:0]     data,
    output logic                      pc_enable,
    output logic                      rx_overflow
);

    wb_state_e                   state_q;
    wb_state_e                   state_d;
    logic [DATA_WIDTH-1:0]       data_d;
    logic                        we_d;
    logic [REG_ADDR_WIDTH-1:0]   addr_d;
    logic                        pc_en_d;
    logic                        take;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic [UART_BYTE_W-1:0]      fifo_rd_data;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [UART_BYTE_W-1:0]      rx_byte;
    logic                        unused_count;

    assign unused_count = ^fifo_count;

    // An empty buffer bypasses the incoming byte straight to the write path
    assign rx_byte   = fifo_empty ? rx_data : fifo_rd_data;
    assign rx_ready  = !fifo_full;
    assign fifo_pop  = take && !fifo_empty;
    assign fifo_push = rx_valid && rx_ready && !(take && fifo_empty);

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (rx_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state and next-output decode
    always_comb begin
        state_d = state_q;
        data_d  = data;
        we_d    = 1'b0;
        addr_d  = rd_addr;
        pc_en_d = pc_enable;
        take    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (UARTtoReg) begin
                    if (!fifo_empty) begin
                        take    = 1'b1;
                        data_d  = DATA_WIDTH'(rx_byte);
                        we_d    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        pc_en_d = 1'b0;
                        state_d = WAIT_IN;
                    end
                end else begin
                    unique case (wb_src_e'(MemtoReg))
                        SRC_MEM: begin
                            data_d = read_data;
                            we_d   = 1'b1;
                        end
                        SRC_ALU: begin
                            data_d = alu_result;
                            we_d   = 1'b1;
                        end
                        SRC_PC: begin
                            data_d = DATA_WIDTH'(pc);
                            we_d   = 1'b1;
                        end
                        default: begin
                            data_d = data;
                        end
                    endcase
                end
            end
            WAIT_IN: begin
                pc_en_d = 1'b0;
                if (!fifo_empty || rx_valid) begin
                    take    = 1'b1;
                    data_d  = DATA_WIDTH'(rx_byte);
                    we_d    = 1'b1;
                    pc_en_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (distinct) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; overflow flag is sticky until reset
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            data             <= '0;
            reg_write_enable <= 1'b0;
            reg_write_addr   <= '0;
            pc_enable        <= 1'b1;
            rx_overflow      <= 1'b0;
        end else begin
            state_q          <= state_d;
            data             <= data_d;
            reg_write_enable <= we_d;
            reg_write_addr   <= addr_d;
            pc_enable        <= pc_en_d;
            if (rx_valid && !rx_ready) begin
                rx_overflow <= 1'b1;
            end
        end
    end

endmodule
